dmem_access_ctrl: RTL

Memory-access controller between the CPU's MEM-stage request and the word-organised data memory `dmem`. It converts byte-addressed lw/lh/lhu/lb/lbu/sw/sh/sb requests into `dmem` word accesses and performs sign or zero extension on loads. `dmem` only writes low lanes for sub-word stores, so an sh or sb at a non-zero lane offset is done as a read-modify-write of the full word. One request is in flight at a time, with valid/ready on both the request and response sides.

---
 rtl/dmem_ctrl_pkg.sv | 36 +++
 rtl/dmem_lane_unit.sv | 45 ++++
 rtl/dmem_access_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/dmem_ctrl_pkg.sv
// Shared encodings for the data-memory access controller: access sizes,
// FSM states, the mapped address window and the request legality check.
package dmem_ctrl_pkg;

  // Access sizes; the same encoding drives dmem's store_format_signal.
  localparam logic [1:0] SZ_WORD    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_BYTE    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  // Size of the byte window mapped onto dmem, starting at ADDR_OFFSET.
  localparam logic [31:0] OFF_RANGE = 32'd4096;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_RMW_RD,
    ST_RMW_WR,
    ST_RESP
  } state_e;

  // A request is rejected when it falls outside the window, uses the
  // reserved size code, or is not naturally aligned for its size.
  function automatic logic addr_error(input logic [31:0] off,
                                      input logic [1:0]  size);
    logic misaligned;
    case (size)
      SZ_WORD: misaligned = (off[1:0] != 2'b00);
      SZ_HALF: misaligned = off[0];
      default: misaligned = 1'b0;
    endcase
    return (off >= OFF_RANGE) || (size == SZ_ILLEGAL) || misaligned;
  endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Byte-lane datapath: extracts and extends sub-word load data, and merges
// sub-word store data into a full word for read-modify-write stores.
module dmem_lane_unit
  import dmem_ctrl_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [31:0] shifted;

  // Little-endian: lane k sits at bits [8k+7:8k], so shift it down to bit 0.
  assign shifted = word_i >> {lane_i, 3'b000};

  // Right-align the addressed lane and sign- or zero-extend it.
  always_comb begin
    // NOTE: every combinational output gets a value on every path (default
    // first) so no latch is inferred when a case arm does not assign it.
    load_o = word_i;
    case (size_i)
      SZ_HALF: load_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
      SZ_BYTE: load_o = {{24{~unsigned_i & shifted[7]}},  shifted[7:0]};
      default: load_o = word_i;
    endcase
  end

  // Overlay the store data onto the addressed lane of the current word.
  always_comb begin
    merge_o = word_i;
    case (size_i)
      SZ_HALF: begin
        if (lane_i[1]) merge_o[31:16] = wdata_i[15:0];
        else           merge_o[15:0]  = wdata_i[15:0];
      end
      SZ_BYTE: merge_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
      default: merge_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage to dmem access controller. Accepts one byte-addressed load or
// store at a time, turns it into word accesses (read-modify-write for
// sub-word stores at a non-zero lane) and returns extended load data.
module dmem_access_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int unsigned DM_AW       = 11,
  parameter logic [31:0] ADDR_OFFSET = 32'h1001_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_rdata,
  output logic             resp_addr_err,
  output logic             dm_w,
  output logic             dm_r,
  output logic [1:0]       store_format_signal,
  output logic [DM_AW-1:0] dm_addr,
  output logic [31:0]      dm_wdata,
  input  logic [31:0]      dm_rdata
);

  state_e           state_q, state_d;
  logic             we_q, we_d;
  logic [1:0]       size_q, size_d;
  logic             uns_q, uns_d;
  logic [1:0]       lane_q, lane_d;
  logic [DM_AW-1:0] addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;   // store data, later the merged word
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  logic [31:0]      off;
  logic             req_err;
  logic [31:0]      load_data;
  logic [31:0]      merge_data;

  assign off     = req_addr - ADDR_OFFSET;
  assign req_err = addr_error(off, req_size);

  dmem_lane_unit u_lane (
    .word_i     (dm_rdata),
    .lane_i     (lane_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .wdata_i    (wdata_q),
    .load_o     (load_data),
    .merge_o    (merge_data)
  );

  // Next-state and request/response register updates.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    lane_d  = lane_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          lane_d  = off[1:0];
          addr_d  = DM_AW'(off[11:2]);
          wdata_d = req_wdata;
          rdata_d = '0;
          err_d   = req_err;
          if (req_err)                                   state_d = ST_RESP;
          else if (!req_we)                              state_d = ST_RD;
          else if (req_size == SZ_WORD || off[1:0] == 2'b00) state_d = ST_WR;
          else                                           state_d = ST_RMW_RD;
        end
      end
      ST_RD: begin
        rdata_d = load_data;
        state_d = ST_RESP;
      end
      ST_WR:     state_d = ST_RESP;
      ST_RMW_RD: begin
        wdata_d = merge_data;
        state_d = ST_RMW_WR;
      end
      ST_RMW_WR: state_d = ST_RESP;
      ST_RESP:   if (resp_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State and request registers; reset drops any in-flight access.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      size_q  <= SZ_WORD;
      uns_q   <= 1'b0;
      lane_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      lane_q  <= lane_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Handshake and dmem strobes decoded from the state register alone.
  always_comb begin
    req_ready           = (state_q == ST_IDLE);
    resp_valid          = (state_q == ST_RESP);
    dm_r                = (state_q == ST_RD) || (state_q == ST_RMW_RD);
    dm_w                = (state_q == ST_WR) || (state_q == ST_RMW_WR);
    store_format_signal = (state_q == ST_WR) ? size_q : SZ_WORD;
    dm_wdata            = dm_w ? wdata_q : '0;
  end

  assign dm_addr       = addr_q;
  assign resp_rdata    = rdata_q;
  assign resp_addr_err = err_q;

endmodule
